// File: rtl/game_sequencer_if.sv
// Handshake bundle between the Flappy Bird sequencer and its controls/datapath.
// The master side drives the buttons and collide flag; the slave is the sequencer.
`timescale 1ns/1ps

interface game_sequencer_if;
    logic       restart;
    logic       mode;
    logic       collide;
    logic [1:0] state;
    logic       move_tick;
    logic       load_level;
    logic       hard;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic       beep;
    logic [7:0] blue_mask;

    modport master (
        output restart, mode, collide,
        input  state, move_tick, load_level, hard, sec_ones, sec_tens, beep, blue_mask
    );

    modport slave (
        input  restart, mode, collide,
        output state, move_tick, load_level, hard, sec_ones, sec_tens, beep, blue_mask
    );
endinterface

// File: rtl/game_sequencer.sv
// Game-flow controller: IDLE/PLAY/CRASH/WIN FSM, move/second enables, BCD play timer.
// Define BEEP_CHIRP_EN to make the crash buzzer chirp instead of sounding steadily.
`timescale 1ns/1ps

module game_sequencer #(
    parameter int MOVE_DIV = 12500000,
    parameter int SEC_DIV  = 50000000,
    parameter int WIN_SECS = 60,
    parameter int BEEP_DIV = 6250000
) (
    input logic              CLK,
    input logic              restart_n,
    game_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        CRASH = 2'd2,
        WIN   = 2'd3
    } state_t;

    localparam int         MW       = $clog2(MOVE_DIV);
    localparam int         SW       = $clog2(SEC_DIV);
    localparam logic [3:0] WIN_TENS = 4'(WIN_SECS / 10);

    state_t        r_state;
    logic          r_moveTick;
    logic          r_loadLevel;
    logic          r_hard;
    logic [3:0]    r_secOnes;
    logic [3:0]    r_secTens;
    logic          r_beep;
    logic [7:0]    r_blueMask;
    logic          r_sync1;
    logic          r_sync2;
    logic          r_sync3;
    logic [MW-1:0] r_moveCnt;
    logic [SW-1:0] r_secCnt;

    logic          w_start;
    logic          w_moveTerm;
    logic          w_secTerm;
    logic [3:0]    w_onesNext;
    logic [3:0]    w_tensNext;

`ifdef BEEP_CHIRP_EN
    localparam int BW = $clog2(BEEP_DIV + 1);
    logic [BW-1:0] r_beepCnt;
`endif

    // The restart button is asynchronous; a held press must yield a single event.
    always_ff @(posedge CLK or negedge restart_n) begin
        if (!restart_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= bus.restart;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_start    = r_sync2 & ~r_sync3;
    assign w_moveTerm = (r_moveCnt == MW'(MOVE_DIV - 1));
    assign w_secTerm  = (r_secCnt == SW'(SEC_DIV - 1));

    always_comb begin
        w_onesNext = r_secOnes + 4'd1;
        w_tensNext = r_secTens;
        if (r_secOnes == 4'd9) begin
            w_onesNext = 4'd0;
            w_tensNext = r_secTens + 4'd1;
        end
    end

    always_ff @(posedge CLK or negedge restart_n) begin
        if (!restart_n) begin
            r_state     <= IDLE;
            r_moveTick  <= 1'b0;
            r_loadLevel <= 1'b0;
            r_hard      <= 1'b0;
            r_secOnes   <= 4'd0;
            r_secTens   <= 4'd0;
            r_beep      <= 1'b0;
            r_blueMask  <= 8'hFF;
            r_moveCnt   <= '0;
            r_secCnt    <= '0;
`ifdef BEEP_CHIRP_EN
            r_beepCnt   <= '0;
`endif
        end else begin
            r_moveTick  <= 1'b0;
            r_loadLevel <= 1'b0;
            if (w_start) begin
                r_state     <= PLAY;
                r_loadLevel <= 1'b1;
                r_hard      <= bus.mode;
                r_secOnes   <= 4'd0;
                r_secTens   <= 4'd0;
                r_moveCnt   <= '0;
                r_secCnt    <= '0;
                r_beep      <= 1'b0;
                r_blueMask  <= 8'hFF;
            end else begin
                case (r_state)
                    PLAY: begin
                        // A crash freezes everything, including any tick due this cycle.
                        if (bus.collide) begin
                            r_state    <= CRASH;
                            r_beep     <= 1'b1;
                            r_blueMask <= 8'hAA;
`ifdef BEEP_CHIRP_EN
                            r_beepCnt  <= '0;
`endif
                        end else begin
                            r_moveTick <= w_moveTerm;
                            r_moveCnt  <= w_moveTerm ? '0 : r_moveCnt + MW'(1);
                            r_secCnt   <= w_secTerm ? '0 : r_secCnt + SW'(1);
                            if (w_secTerm) begin
                                r_secOnes <= w_onesNext;
                                r_secTens <= w_tensNext;
                                if (w_tensNext == WIN_TENS && w_onesNext == 4'd0) begin
                                    r_state    <= WIN;
                                    r_blueMask <= 8'h00;
                                end
                            end
                        end
                    end
                    CRASH: begin
`ifdef BEEP_CHIRP_EN
                        if (r_beepCnt == BW'(BEEP_DIV - 1)) begin
                            r_beepCnt <= '0;
                            r_beep    <= ~r_beep;
                        end else begin
                            r_beepCnt <= r_beepCnt + BW'(1);
                        end
`else
                        r_beep <= 1'b1;
`endif
                    end
                    default: begin
                        r_beep <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.state      = r_state;
    assign bus.move_tick  = r_moveTick;
    assign bus.load_level = r_loadLevel;
    assign bus.hard       = r_hard;
    assign bus.sec_ones   = r_secOnes;
    assign bus.sec_tens   = r_secTens;
    assign bus.beep       = r_beep;
    assign bus.blue_mask  = r_blueMask;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with short dividers (move 4, sec 10, win at 20 s).
// Outputs are sampled and inputs driven on the falling clock edge.
`timescale 1ns/1ps

module tb_game_sequencer;

    logic CLK;
    logic restart_n;
    int   checks;
    int   errors;
    int   tickCnt;
    int   loadCnt;
    int   found;
    int   secExp;

    game_sequencer_if gsIf ();

    game_sequencer #(
        .MOVE_DIV (4),
        .SEC_DIV  (10),
        .WIN_SECS (20),
        .BEEP_DIV (3)
    ) dut (
        .CLK       (CLK),
        .restart_n (restart_n),
        .bus       (gsIf.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected summary before 200000ns");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".state"}, gsIf.state, 0);
        checkOutput({tag, ".tick"},  gsIf.move_tick, 0);
        checkOutput({tag, ".load"},  gsIf.load_level, 0);
        checkOutput({tag, ".hard"},  gsIf.hard, 0);
        checkOutput({tag, ".sec"},   {gsIf.sec_tens, gsIf.sec_ones}, 8'h00);
        checkOutput({tag, ".beep"},  gsIf.beep, 0);
        checkOutput({tag, ".mask"},  gsIf.blue_mask, 8'hFF);
    endtask

    // Raise restart and wait (bounded) for the resulting load_level pulse.
    task automatic startGame(input logic m);
        gsIf.mode    = m;
        gsIf.restart = 1'b1;
        found = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (gsIf.load_level === 1'b1) begin
                found = 1;
                break;
            end
        end
        checkOutput("loadSeen", found, 1);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        restart_n    = 1'b0;
        gsIf.restart = 1'b0;
        gsIf.mode    = 1'b0;
        gsIf.collide = 1'b0;
        applyStimulus(3);
        checkResetValues("reset");

        // Idle for 100 cycles; mode wiggles must not reach hard.
        restart_n = 1'b1;
        tickCnt = 0;
        loadCnt = 0;
        for (int i = 0; i < 100; i++) begin
            gsIf.mode = i[0];
            @(negedge CLK);
            tickCnt += int'(gsIf.move_tick);
            loadCnt += int'(gsIf.load_level);
        end
        checkOutput("idleTicks", tickCnt, 0);
        checkOutput("idleLoads", loadCnt, 0);
        checkResetValues("idle");

        // Hard game, crash at 03 on a tick slot.
        startGame(1'b1);
        gsIf.restart = 1'b0;
        checkOutput("play1.state", gsIf.state, 1);
        checkOutput("play1.hard",  gsIf.hard, 1);
        checkOutput("play1.sec",   {gsIf.sec_tens, gsIf.sec_ones}, 8'h00);
        checkOutput("play1.mask",  gsIf.blue_mask, 8'hFF);
        checkOutput("play1.beep",  gsIf.beep, 0);
        for (int k = 1; k <= 35; k++) begin
            @(negedge CLK);
            checkOutput("play1.tick", gsIf.move_tick, (k % 4 == 0) ? 1 : 0);
            checkOutput("play1.load", gsIf.load_level, 0);
            checkOutput("play1.ones", gsIf.sec_ones, k / 10);
            checkOutput("play1.st",   gsIf.state, 1);
        end
        gsIf.collide = 1'b1;
        @(negedge CLK);
        gsIf.collide = 1'b0;
        gsIf.mode    = 1'b0;
        checkOutput("crash.state", gsIf.state, 2);
        checkOutput("crash.tick",  gsIf.move_tick, 0);
        checkOutput("crash.beep",  gsIf.beep, 1);
        checkOutput("crash.mask",  gsIf.blue_mask, 8'hAA);
        checkOutput("crash.sec",   {gsIf.sec_tens, gsIf.sec_ones}, 8'h03);
        tickCnt = 0;
        for (int j = 1; j <= 200; j++) begin
            @(negedge CLK);
            tickCnt += int'(gsIf.move_tick);
`ifdef BEEP_CHIRP_EN
            checkOutput("crash.chirp", gsIf.beep, ((j / 3) % 2 == 0) ? 1 : 0);
`else
            checkOutput("crash.beepHold", gsIf.beep, 1);
`endif
        end
        checkOutput("crashHold.ticks", tickCnt, 0);
        checkOutput("crashHold.state", gsIf.state, 2);
        checkOutput("crashHold.sec",   {gsIf.sec_tens, gsIf.sec_ones}, 8'h03);
        checkOutput("crashHold.hard",  gsIf.hard, 1);
        checkOutput("crashHold.mask",  gsIf.blue_mask, 8'hAA);

        // Restart from CRASH with collide high (ignored until PLAY), button held.
        gsIf.collide = 1'b1;
        gsIf.mode    = 1'b0;
        gsIf.restart = 1'b1;
        found = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (gsIf.load_level === 1'b1) begin
                found = 1;
                break;
            end
            checkOutput("restart.crashState", gsIf.state, 2);
        end
        checkOutput("restart.loadSeen", found, 1);
        gsIf.collide = 1'b0;
        checkOutput("restart.state", gsIf.state, 1);
        checkOutput("restart.hard",  gsIf.hard, 0);
        checkOutput("restart.sec",   {gsIf.sec_tens, gsIf.sec_ones}, 8'h00);
        checkOutput("restart.beep",  gsIf.beep, 0);
        checkOutput("restart.mask",  gsIf.blue_mask, 8'hFF);
        loadCnt = 0;
        for (int k = 1; k <= 230; k++) begin
            if (k == 51) gsIf.restart = 1'b0;
            @(negedge CLK);
            loadCnt += int'(gsIf.load_level);
            secExp = (k < 200) ? k / 10 : 20;
            checkOutput("run.sec", {gsIf.sec_tens, gsIf.sec_ones}, {4'(secExp / 10), 4'(secExp % 10)});
            checkOutput("run.state", gsIf.state, (k < 200) ? 1 : 3);
            checkOutput("run.mask",  gsIf.blue_mask, (k < 200) ? 8'hFF : 8'h00);
            if (k != 200)
                checkOutput("run.tick", gsIf.move_tick, (k < 200 && k % 4 == 0) ? 1 : 0);
            if (k >= 200)
                checkOutput("win.beep", gsIf.beep, 0);
        end
        checkOutput("run.extraLoads", loadCnt, 0);

        // Restart from WIN, then async reset at 05.
        startGame(1'b1);
        gsIf.restart = 1'b0;
        checkOutput("play3.state", gsIf.state, 1);
        checkOutput("play3.hard",  gsIf.hard, 1);
        applyStimulus(55);
        checkOutput("play3.sec", {gsIf.sec_tens, gsIf.sec_ones}, 8'h05);
        restart_n = 1'b0;
        #1;
        checkResetValues("asyncReset");
        applyStimulus(2);
        restart_n = 1'b1;
        tickCnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            tickCnt += int'(gsIf.move_tick);
        end
        checkOutput("postReset.ticks", tickCnt, 0);
        checkResetValues("postReset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
Top-level game-flow controller for the 8x8 LED Flappy Bird game. It owns the IDLE/PLAY/CRASH/WIN state machine and generates the single-cycle move and second enables that advance the bird/pipe datapath. It also runs the 0-59 BCD play timer for the 7-segment mux, latches the difficulty mode, and drives the buzzer and the blue-layer overlay mask. It replaces the free-running divided clocks with enables in the CLK domain.

Parameters:
MOVE_DIV, 12500000, CLK cycles between move_tick pulses (minimum 2)
SEC_DIV, 50000000, CLK cycles between timer increments (minimum 2)
WIN_SECS, 60, timer value that ends the game as a win (multiple of 10, range 10..90)
BEEP_DIV, 6250000, CLK cycles per buzzer half-period (used only with the optional feature)

Ports:
CLK  in  1  system clock
restart_n  in  1  asynchronous active-low reset
restart  in  1  game restart button, active high, asynchronous to CLK
mode  in  1  difficulty select, 1 = hard; sampled only at game start
collide  in  1  datapath flag: the bird cell overlaps a pipe cell in the bird column
state  out  2  0 = IDLE, 1 = PLAY, 2 = CRASH, 3 = WIN
move_tick  out  1  one-cycle enable: the datapath steps the bird and pipes
load_level  out  1  one-cycle pulse: the datapath reloads its initial bird/pipe/pattern set
hard  out  1  mode latched at game start
sec_ones  out  4  BCD units of elapsed seconds
sec_tens  out  4  BCD tens of elapsed seconds
beep  out  1  buzzer drive
blue_mask  out  8  DATA_B row overlay, active-low

Behaviour:
- Reset (restart_n=0, async) values:
  - state IDLE
  - move_tick, load_level, hard, beep = 0
  - sec_ones, sec_tens = 0
  - blue_mask = 8'hFF
  - both prescalers and the synchronizer cleared
- restart input handling: 2-flop synchronizer, then rising-edge detect. The start event occurs 3 cycles after the input goes high. A held button produces exactly one event.
- Start event, valid in any state. On the following cycle:
  - load_level = 1 for one cycle
  - hard <= mode
  - sec_ones, sec_tens, both prescalers <= 0
  - state <= PLAY
- A start event has priority over collide and over the win condition in the same cycle.
- IDLE:
  - outputs static, no ticks, blue_mask 8'hFF
  - leaves only on a start event
- PLAY:
  - Move prescaler counts 0..MOVE_DIV-1. move_tick = 1 in the cycle the count is MOVE_DIV-1. The first tick occurs MOVE_DIV cycles after the load_level cycle.
  - Sec prescaler counts 0..SEC_DIV-1. At terminal count, increment the timer:
    - if sec_ones == 9: ones <= 0, tens <= tens+1
    - otherwise: ones+1
  - collide == 1 in any PLAY cycle: state <= CRASH next cycle. A move_tick or timer increment in that same cycle is suppressed.
  - When the timer becomes {tens,ones} == WIN_SECS/10,0: state <= WIN on the next cycle. The timer holds that value.
  - collide and the win increment in the same cycle: CRASH wins.
- CRASH:
  - timer frozen, no move_tick
  - blue_mask = 8'hAA
  - beep = 1
  - exits only on a start event
- WIN:
  - timer frozen at WIN_SECS, no move_tick
  - blue_mask = 8'h00
  - beep = 0
  - exits only on a start event
- Leaving CRASH: beep falls in the same cycle state changes.
- collide is ignored outside PLAY.
- mode changes outside a start event have no effect on hard.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Async reset asserted mid-game returns everything to reset values immediately. After release, the block waits in IDLE.

Optional Feature:
BEEP_CHIRP_EN:
- Defined: in CRASH, beep toggles every BEEP_DIV cycles, starting high on the first CRASH cycle, using a dedicated counter cleared on CRASH entry.
- Undefined: beep is steady 1 in CRASH and the counter is not built.
- All other states drive beep = 0 in both builds.

Test Plan:
1. Release reset, hold restart=0 for 100 cycles -> state=0, sec=00, blue_mask=FF, no move_tick or load_level.
2. Overrides MOVE_DIV=4, SEC_DIV=10, WIN_SECS=10; mode=1; pulse restart, then collide=0 -> load_level once, hard=1. Then move_tick every 4 cycles; sec_ones increments every 10 cycles; at 10 seconds sec={1,0} and state=3, blue_mask=00, ticks stop.
3. In PLAY at sec=03, raise collide for 1 cycle coincident with a move_tick slot -> tick suppressed, state=2 next cycle, beep=1, blue_mask=AA, timer frozen at 03 for 200 cycles.
4. From CRASH, assert restart with mode=0 and hold it 50 cycles -> exactly one load_level, hard=0, sec=00, state=1; collide ignored until PLAY.
5. WIN_SECS=20 -> carry 09 to 10, then WIN at exactly {2,0}.
6. Drop restart_n mid-PLAY at sec=05 -> all outputs at reset values the same cycle, state=0 after release. With BEEP_CHIRP_EN and BEEP_DIV=3 in CRASH -> beep pattern 1,1,1,0,0,0 repeating.
